coax_rx_controller: RTL and testbench
=====================================

Name: coax_rx_controller

Overview:
Sequences the buffered coax receiver after the transmitter finishes a command.
- Arms on `start`, waits for a response frame with a timeout, then drains the receive FIFO.
- Presents words to the host on a valid/ready stream, with `out_last` on the final word of each frame.
- Converts receiver errors and timeouts into a single terminating status word, then clears the receiver.

Parameters:
- TIMEOUT_CYCLES, 1200: clocks to wait after `start` for `rx_active` or a non-empty FIFO before reporting a timeout.
- MAX_WORDS, 256: frame length limit in words; used only when COAX_RX_CONTROLLER_LENGTH_LIMIT_EN is defined.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: arm for a response; ignored unless IDLE
- rx_active  input  1  buffered receiver frame-in-progress
- rx_error  input  1  buffered receiver error flag
- rx_data  input  10  buffered receiver data (FIFO head, or error code when rx_error)
- rx_empty  input  1  buffered receiver FIFO empty
- rx_read_strobe  output  1  pops the FIFO head; combinational, one cycle per word
- rx_reset  output  1  synchronous active-high clear to the buffered receiver
- out_data  output  10  word or status code
- out_valid  output  1  out_data/out_last/out_error valid
- out_ready  input  1  host accepts when out_valid && out_ready
- out_last  output  1  final word of the response
- out_error  output  1  out_data is a status code, not a data word
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; counters 0; hold register empty. Reset mid-frame discards everything.
- Pop rule: `rx_read_strobe` = state DRAIN && !rx_empty && !rx_error && hold register empty. The FIFO is first-word fall-through: rx_data is valid whenever !rx_empty. The word is captured into the hold register on the same edge it is popped.
- IDLE: on `start`, go to WAIT. The timeout counter loads 0.
- WAIT: the counter increments each clock.
  - rx_active or !rx_empty -> DRAIN.
  - rx_error -> ERR, capturing rx_data.
  - counter == TIMEOUT_CYCLES-1 with none of the above -> ERR with code COAX_STATUS_TIMEOUT.
- DRAIN:
  - Pop into the hold register while the pop rule holds.
  - When the hold register is full, look ahead:
    - if !rx_empty, go to PRESENT with last=0;
    - if !rx_active && rx_empty, the frame has ended: go to PRESENT with last=1.
  - rx_error in DRAIN or PRESENT takes priority over everything: discard the hold word and go to ERR capturing rx_data.
- PRESENT: out_valid=1 and out_last=latched last.
  - The latched value must not change while out_valid is high.
  - On handshake: last=1 -> IDLE; last=0 -> DRAIN.
  - The host may hold out_ready low indefinitely; the FIFO absorbs backpressure, and overflow surfaces as rx_error.
- ERR: out_valid=1, out_error=1, out_last=1, out_data=captured code.
  - On handshake -> CLEAR.
- CLEAR: rx_reset=1 for exactly one cycle -> IDLE.
- Latency: a FIFO word reaches out_valid 2 clocks after it becomes head, given out_ready high and lookahead satisfied.
- A `start` pulse while busy is ignored.
- An empty frame (rx_active falls with no words) yields no data. The controller stays in DRAIN until the timeout counter, still running, expires -> timeout status.
- The counter stops on the first word captured.

Optional Feature:
- COAX_RX_CONTROLLER_LENGTH_LIMIT_EN.
- Defined: an 8+ bit word counter per frame. Capturing word number MAX_WORDS+1 discards that word and goes to ERR with COAX_STATUS_LENGTH; the FIFO is then cleared via CLEAR.
- Undefined: no counter and frames are unbounded; MAX_WORDS is ignored.

Decomposition:
Shared package coax_pkg holds the status codes as 10-bit constants:
- COAX_STATUS_OVERFLOW = 10'b0000001000 (matches the buffered receiver)
- COAX_STATUS_TIMEOUT = 10'b0000100000
- COAX_STATUS_LENGTH = 10'b0001000000
- state encoding IDLE/WAIT/DRAIN/PRESENT/ERR/CLEAR

One sub-module, coax_timeout_counter: load, enable, terminal-count pulse, parameterised by TIMEOUT_CYCLES.

Test Plan:
- start, then a 3-word frame 0x155, 0x2AA, 0x001 with out_ready=1 -> three handshakes in order; out_last only on 0x001; no out_error; busy drops after the third word.
- start, no rx activity -> after exactly 1200 clocks out_valid=1, out_error=1, out_last=1, out_data=0x020; then one rx_reset pulse.
- Frame of 5 words with out_ready held low for 100 clocks -> out_valid stays high and stable on word 0; all 5 words delivered after release; one pop per handshake.
- rx_error with rx_data=0x008 after 2 words delivered and 1 held -> held word dropped; status 0x008 with out_error/out_last; rx_reset pulse; return to IDLE.
- reset_n asserted mid-DRAIN -> all outputs 0 immediately; a following start behaves as the first scenario.
- With COAX_RX_CONTROLLER_LENGTH_LIMIT_EN and MAX_WORDS=4, a 6-word frame -> 4 data words with out_last=0, then status 0x040 with out_last=1 and an rx_reset pulse.

Source files
------------

// File: rtl/coax_pkg.sv
// Shared coax receive definitions: status codes reported on the host stream
// and the receive controller state encoding.
package coax_pkg;

    // Receiver overflow code, as produced by the buffered receiver itself
    localparam logic [9:0] COAX_STATUS_OVERFLOW = 10'b0000001000;
    // No response activity within the timeout window
    localparam logic [9:0] COAX_STATUS_TIMEOUT  = 10'b0000100000;
    // Response frame longer than the configured word limit
    localparam logic [9:0] COAX_STATUS_LENGTH   = 10'b0001000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN,
        ST_PRESENT,
        ST_ERR,
        ST_CLEAR
    } coax_state_t;

endpackage

// File: rtl/coax_timeout_counter.sv
// Response timeout counter: cleared by load, counts while enabled and
// saturates at TIMEOUT_CYCLES-1, where it flags expiry.
module coax_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count enabled clocks; hold at the terminal value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= '0;
        else if (enable && (count != LAST))
            count <= count + CW'(1);
    end

    assign expired = enable && !load && (count == LAST);

endmodule

// File: rtl/coax_rx_controller.sv
// Coax receive controller: arms on start, waits for a response with timeout,
// drains the FIFO one word at a time through a hold register onto a
// valid/ready stream, and turns errors/timeouts into one status word
// followed by a one-cycle receiver clear.
// Optional build macro: COAX_RX_CONTROLLER_LENGTH_LIMIT_EN enables a per-frame
// word limit of MAX_WORDS.
module coax_rx_controller
    import coax_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1200,
    parameter int MAX_WORDS      = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rx_active,
    input  logic       rx_error,
    input  logic [9:0] rx_data,
    input  logic       rx_empty,
    output logic       rx_read_strobe,
    output logic       rx_reset,
    output logic [9:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       out_error,
    output logic       busy
);

    coax_state_t state, state_n;

    logic       hold_valid;
    logic [9:0] hold_data;
    logic       last_q;
    logic [9:0] err_code;
    logic       got_word;

    logic       pop;
    logic       hold_ld, hold_clr;
    logic       last_ld, last_val;
    logic       err_ld;
    logic [9:0] err_val;
    logic       tmo_expired;

`ifdef COAX_RX_CONTROLLER_LENGTH_LIMIT_EN
    localparam int WCW = ($clog2(MAX_WORDS + 2) > 8) ? $clog2(MAX_WORDS + 2) : 8;
    localparam logic [WCW-1:0] WLIMIT = WCW'(MAX_WORDS);
    logic [WCW-1:0] word_cnt;
    logic           over_limit;
    assign over_limit = (word_cnt == WLIMIT);
`else
    logic unused_max_words;
    assign unused_max_words = (MAX_WORDS > 0);
`endif

    // Timeout runs in WAIT and in DRAIN until the first word is captured
    coax_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state == ST_IDLE),
        .enable  ((state == ST_WAIT) || ((state == ST_DRAIN) && !got_word)),
        .expired (tmo_expired)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next state and datapath controls
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        hold_ld  = 1'b0;
        hold_clr = 1'b0;
        last_ld  = 1'b0;
        last_val = 1'b0;
        err_ld   = 1'b0;
        err_val  = rx_data;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (rx_error) begin
                    err_ld  = 1'b1;
                    state_n = ST_ERR;
                end else if (rx_active || !rx_empty) begin
                    state_n = ST_DRAIN;
                end else if (tmo_expired) begin
                    err_ld  = 1'b1;
                    err_val = COAX_STATUS_TIMEOUT;
                    state_n = ST_ERR;
                end
            end
            ST_DRAIN: begin
                if (rx_error) begin
                    hold_clr = 1'b1;
                    err_ld   = 1'b1;
                    state_n  = ST_ERR;
                end else if (!hold_valid) begin
                    if (!rx_empty) begin
                        pop = 1'b1;
`ifdef COAX_RX_CONTROLLER_LENGTH_LIMIT_EN
                        // The popped over-limit word is dropped, not held
                        if (over_limit) begin
                            err_ld  = 1'b1;
                            err_val = COAX_STATUS_LENGTH;
                            state_n = ST_ERR;
                        end else begin
                            hold_ld = 1'b1;
                        end
`else
                        hold_ld = 1'b1;
`endif
                    end else if (tmo_expired) begin
                        // Empty frame: nothing ever arrived
                        err_ld  = 1'b1;
                        err_val = COAX_STATUS_TIMEOUT;
                        state_n = ST_ERR;
                    end
                end else if (!rx_empty) begin
                    last_ld  = 1'b1;
                    last_val = 1'b0;
                    state_n  = ST_PRESENT;
                end else if (!rx_active) begin
                    // Frame ended and FIFO is dry: held word is the last one
                    last_ld  = 1'b1;
                    last_val = 1'b1;
                    state_n  = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (rx_error) begin
                    hold_clr = 1'b1;
                    err_ld   = 1'b1;
                    state_n  = ST_ERR;
                end else if (out_ready) begin
                    hold_clr = 1'b1;
                    state_n  = last_q ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_ERR: begin
                if (out_ready)
                    state_n = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Hold register, last flag, status code and first-word tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            last_q     <= 1'b0;
            err_code   <= '0;
            got_word   <= 1'b0;
        end else begin
            if (hold_clr) begin
                hold_valid <= 1'b0;
            end else if (hold_ld) begin
                hold_valid <= 1'b1;
                hold_data  <= rx_data;
            end
            if (last_ld)
                last_q <= last_val;
            if (err_ld)
                err_code <= err_val;
            if (state == ST_IDLE)
                got_word <= 1'b0;
            else if (hold_ld)
                got_word <= 1'b1;
        end
    end

`ifdef COAX_RX_CONTROLLER_LENGTH_LIMIT_EN
    // Words captured in the current frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            word_cnt <= '0;
        else if (state == ST_IDLE)
            word_cnt <= '0;
        else if (hold_ld)
            word_cnt <= word_cnt + WCW'(1);
    end
`endif

    assign rx_read_strobe = pop;
    assign rx_reset       = (state == ST_CLEAR);
    assign out_valid      = (state == ST_PRESENT) || (state == ST_ERR);
    assign out_error      = (state == ST_ERR);
    assign out_last       = (state == ST_ERR) || ((state == ST_PRESENT) && last_q);
    assign out_data       = (state == ST_ERR)     ? err_code  :
                            (state == ST_PRESENT) ? hold_data : '0;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_coax_rx_controller.sv
// Directed bench for coax_rx_controller with a first-word fall-through FIFO
// model on the receiver side.
module tb_coax_rx_controller;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       start     = 1'b0;
    logic       rx_active = 1'b0;
    logic       rx_error  = 1'b0;
    logic [9:0] rx_data   = '0;
    logic       rx_empty  = 1'b1;
    logic       out_ready = 1'b0;
    logic       rx_read_strobe, rx_reset, out_valid, out_last, out_error, busy;
    logic [9:0] out_data;

    logic [9:0] fifo[$];
    logic [9:0] err_val = '0;
    int pops    = 0;
    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    coax_rx_controller #(.TIMEOUT_CYCLES(1200), .MAX_WORDS(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .rx_active      (rx_active),
        .rx_error       (rx_error),
        .rx_data        (rx_data),
        .rx_empty       (rx_empty),
        .rx_read_strobe (rx_read_strobe),
        .rx_reset       (rx_reset),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .out_error      (out_error),
        .busy           (busy)
    );

    task automatic drive_fifo();
        rx_empty = (fifo.size() == 0);
        if (rx_error)
            rx_data = err_val;
        else
            rx_data = (fifo.size() != 0) ? fifo[0] : 10'h000;
    endtask

    // One clock: sample pop/clear away from the edge, then update the FIFO
    task automatic step();
        logic pop_s, clr_s;
        @(negedge clk);
        pop_s = rx_read_strobe;
        clr_s = rx_reset;
        @(posedge clk);
        #1;
        if (clr_s)
            fifo.delete();
        else if (pop_s && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        drive_fifo();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for out_valid, check the word, then take the handshake
    task automatic expect_word(input string tag, input logic [9:0] d, input logic l,
                               input logic e, output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'(1));
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_last"},  32'(out_last),  32'(l));
        chk({tag, "_err"},   32'(out_error), 32'(e));
        step();
    endtask

    task automatic run_basic(input string tag);
        int n, p0;
        p0 = pops;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        fifo.push_back(10'h155);
        fifo.push_back(10'h2AA);
        fifo.push_back(10'h001);
        drive_fifo();
        expect_word({tag, "_w0"}, 10'h155, 1'b0, 1'b0, n);
        chk({tag, "_lat0"}, 32'(n), 32'(3));
        expect_word({tag, "_w1"}, 10'h2AA, 1'b0, 1'b0, n);
        chk({tag, "_lat1"}, 32'(n), 32'(2));
        expect_word({tag, "_w2"}, 10'h001, 1'b1, 1'b0, n);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_pops"}, 32'(pops - p0), 32'(3));
    endtask

    initial begin
        int n, p0;
        logic stable;
        logic [9:0] w3[5];
        logic [9:0] w6[6];
        w3 = '{10'h3FF, 10'h000, 10'h123, 10'h2AA, 10'h155};
        w6 = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h066};

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_busy",  32'(busy),      32'(0));
        chk("rst_clr",   32'(rx_reset),  32'(0));
        chk("rst_pop",   32'(rx_read_strobe), 32'(0));
        reset_n = 1'b1;
        step();

        // Three-word frame, frame already ended when words land
        run_basic("basic");

        // Timeout; a start while waiting must not restart the window
        out_ready = 1'b1;
        start = 1'b1;
        step();
        n = 0;
        while (!out_valid && n < 1300) begin
            start = (n == 500);
            step();
            n++;
        end
        start = 1'b0;
        chk("tmo_cycles", 32'(n),         32'(1200));
        chk("tmo_data",   32'(out_data),  32'(10'h020));
        chk("tmo_err",    32'(out_error), 32'(1));
        chk("tmo_last",   32'(out_last),  32'(1));
        step();
        chk("tmo_clr",    32'(rx_reset),  32'(1));
        chk("tmo_novld",  32'(out_valid), 32'(0));
        step();
        chk("tmo_clr_off", 32'(rx_reset), 32'(0));
        chk("tmo_idle",    32'(busy),     32'(0));

        // Backpressure: five words, host stalls for 100 clocks
        p0 = pops;
        out_ready = 1'b0;
        rx_active = 1'b1;
        for (int i = 0; i < 5; i++) fifo.push_back(w3[i]);
        drive_fifo();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!(out_valid === 1'b1 && out_data === w3[0] && out_last === 1'b0))
                stable = 1'b0;
            step();
        end
        chk("bp_stable", 32'(stable), 32'(1));
        chk("bp_pops",   32'(pops - p0), 32'(1));
        rx_active = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            expect_word($sformatf("bp_w%0d", i), w3[i], (i == 4), 1'b0, n);
        chk("bp_pops_all", 32'(pops - p0), 32'(5));
        chk("bp_idle",     32'(busy),      32'(0));

        // Receiver error with one word held
        p0 = pops;
        rx_active = 1'b1;
        fifo.push_back(10'h101);
        fifo.push_back(10'h202);
        fifo.push_back(10'h303);
        fifo.push_back(10'h0F0);
        drive_fifo();
        start = 1'b1;
        step();
        start = 1'b0;
        expect_word("er_w0", 10'h101, 1'b0, 1'b0, n);
        expect_word("er_w1", 10'h202, 1'b0, 1'b0, n);
        step();
        chk("er_pops", 32'(pops - p0), 32'(3));
        err_val  = 10'h008;
        rx_error = 1'b1;
        drive_fifo();
        step();
        chk("er_valid", 32'(out_valid), 32'(1));
        chk("er_data",  32'(out_data),  32'(10'h008));
        chk("er_err",   32'(out_error), 32'(1));
        chk("er_last",  32'(out_last),  32'(1));
        rx_error  = 1'b0;
        rx_active = 1'b0;
        drive_fifo();
        step();
        chk("er_clr",  32'(rx_reset), 32'(1));
        step();
        chk("er_idle", 32'(busy), 32'(0));
        chk("er_clr_off", 32'(rx_reset), 32'(0));

        // Asynchronous reset in the middle of a frame
        out_ready = 1'b0;
        rx_active = 1'b1;
        fifo.push_back(10'h3C3);
        fifo.push_back(10'h0C0);
        drive_fifo();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mr_busy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'(0));
        chk("mr_data",  32'(out_data),  32'(0));
        chk("mr_last",  32'(out_last),  32'(0));
        chk("mr_err",   32'(out_error), 32'(0));
        chk("mr_busy0", 32'(busy),      32'(0));
        chk("mr_pop",   32'(rx_read_strobe), 32'(0));
        chk("mr_clr",   32'(rx_reset),  32'(0));
        fifo.delete();
        rx_active = 1'b0;
        drive_fifo();
        #1;
        reset_n = 1'b1;
        step();
        run_basic("after_rst");

        // Six-word frame: limited to four words when the length limit is built in
        p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) fifo.push_back(w6[i]);
        drive_fifo();
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef COAX_RX_CONTROLLER_LENGTH_LIMIT_EN
        for (int i = 0; i < 4; i++)
            expect_word($sformatf("len_w%0d", i), w6[i], 1'b0, 1'b0, n);
        expect_word("len_status", 10'h040, 1'b1, 1'b1, n);
        chk("len_clr",  32'(rx_reset), 32'(1));
        chk("len_pops", 32'(pops - p0), 32'(5));
        step();
        chk("len_idle", 32'(busy), 32'(0));
`else
        for (int i = 0; i < 6; i++)
            expect_word($sformatf("unl_w%0d", i), w6[i], (i == 5), 1'b0, n);
        chk("unl_pops", 32'(pops - p0), 32'(6));
        chk("unl_idle", 32'(busy), 32'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
